// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: state and op encodings plus default sizing.
package mem_arbiter_pkg;

    localparam int unsigned WORD_SIZE_DEF = 16;
    localparam int unsigned LATENCY_DEF   = 4;
    localparam int unsigned CNT_W         = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10,
        DONE   = 2'b11
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    function automatic logic is_busy(input state_e s);
        return (s == BUSY_I) || (s == BUSY_D);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU instruction/data ports and memory port of the arbiter, bundled as one interface.
interface mem_arbiter_if #(
    parameter int unsigned WORD_SIZE = 16
);
    logic                 i_readM;
    logic [WORD_SIZE-1:0] i_address;
    logic [WORD_SIZE-1:0] i_rdata;
    logic                 i_ready;
    logic                 i_stall;

    logic                 d_readM;
    logic                 d_writeM;
    logic [WORD_SIZE-1:0] d_address;
    logic [WORD_SIZE-1:0] d_wdata;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 d_ready;
    logic                 d_stall;

    logic                 m_readM;
    logic                 m_writeM;
    logic [WORD_SIZE-1:0] m_address;
    logic [WORD_SIZE-1:0] m_wdata;
    logic [WORD_SIZE-1:0] m_rdata;

    // Arbiter side
    modport slave (
        input  i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata,
        output i_rdata, i_ready, i_stall, d_rdata, d_ready, d_stall,
               m_readM, m_writeM, m_address, m_wdata
    );

    // CPU + memory side
    modport master (
        output i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata,
        input  i_rdata, i_ready, i_stall, d_rdata, d_ready, d_stall,
               m_readM, m_writeM, m_address, m_wdata
    );
endinterface

// File: rtl/mem_arbiter_latency_counter.sv
// Down-counter timing the memory busy window: load on grant, decrement each busy cycle.
module latency_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         Clk,
    input  logic         Reset_N,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);
    logic [W-1:0] cnt;

    // Saturates at zero so it never wraps past the loaded value
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one fixed-latency memory; data side has priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
    parameter int unsigned LATENCY   = LATENCY_DEF
) (
    input  logic          Clk,
    input  logic          Reset_N,
    mem_arbiter_if.slave  bus
);
    state_e               state_q,     state_d;
    op_e                  op_q,        op_d;
    logic                 m_readM_q,   m_readM_d;
    logic                 m_writeM_q,  m_writeM_d;
    logic [WORD_SIZE-1:0] m_address_q, m_address_d;
    logic [WORD_SIZE-1:0] m_wdata_q,   m_wdata_d;
    logic [WORD_SIZE-1:0] i_rdata_q,   i_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q,   d_rdata_d;
    logic                 i_ready_q,   i_ready_d;
    logic                 d_ready_q,   d_ready_d;
    logic                 cnt_load;
    logic                 cnt_dec;
    logic                 cnt_zero_c;

    latency_counter #(.W(CNT_W)) u_cnt (
        .Clk      (Clk),
        .Reset_N  (Reset_N),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (CNT_W'(LATENCY - 1)),
        .zero_c   (cnt_zero_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        m_readM_d   = m_readM_q;
        m_writeM_d  = m_writeM_q;
        m_address_d = m_address_q;
        m_wdata_d   = m_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.d_readM || bus.d_writeM) begin
                    // A read+write collision is served as a write
                    state_d     = BUSY_D;
                    op_d        = bus.d_writeM ? OP_WR : OP_RD;
                    m_readM_d   = ~bus.d_writeM;
                    m_writeM_d  = bus.d_writeM;
                    m_address_d = bus.d_address;
                    m_wdata_d   = bus.d_wdata;
                    cnt_load    = 1'b1;
                end else if (bus.i_readM) begin
                    state_d     = BUSY_I;
                    op_d        = OP_RD;
                    m_readM_d   = 1'b1;
                    m_writeM_d  = 1'b0;
                    m_address_d = bus.i_address;
                    cnt_load    = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (cnt_zero_c) begin
                    state_d    = DONE;
                    m_readM_d  = 1'b0;
                    m_writeM_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        i_rdata_d = bus.m_rdata;
                        i_ready_d = 1'b1;
                    end else begin
                        d_ready_d = 1'b1;
                        if (op_q == OP_RD) begin
                            d_rdata_d = bus.m_rdata;
                        end
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q     <= IDLE;
            op_q        <= OP_RD;
            m_readM_q   <= 1'b0;
            m_writeM_q  <= 1'b0;
            m_address_q <= '0;
            m_wdata_q   <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            m_readM_q   <= m_readM_d;
            m_writeM_q  <= m_writeM_d;
            m_address_q <= m_address_d;
            m_wdata_q   <= m_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    assign bus.m_readM   = m_readM_q;
    assign bus.m_writeM  = m_writeM_q;
    assign bus.m_address = m_address_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.i_stall   = bus.i_readM & ~i_ready_q;
    assign bus.d_stall   = (bus.d_readM | bus.d_writeM) & ~d_ready_q;

    a_rw_exclusive: assert property (@(posedge Clk) disable iff (!Reset_N)
                                     !(bus.d_readM && bus.d_writeM));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: LATENCY=4 and LATENCY=1 instances sharing one memory model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned W = 16;

    typedef struct {
        logic         wr;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] rdata;
    } sb_t;

    logic Clk     = 1'b0;
    logic Reset_N = 1'b0;

    mem_arbiter_if #(.WORD_SIZE(W)) b4 ();
    mem_arbiter_if #(.WORD_SIZE(W)) b1 ();

    mem_arbiter #(.WORD_SIZE(W), .LATENCY(4)) dut4 (.Clk(Clk), .Reset_N(Reset_N), .bus(b4.slave));
    mem_arbiter #(.WORD_SIZE(W), .LATENCY(1)) dut1 (.Clk(Clk), .Reset_N(Reset_N), .bus(b1.slave));

    always #5 Clk = ~Clk;

    sb_t          iq[$];
    sb_t          dq[$];
    sb_t          iq1[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] mem [logic [W-1:0]];
    int           run4 = 0;
    int           run1 = 0;
    logic [W-1:0] last_d_rd = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mem_rd(input logic [W-1:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 16'hA5A5);
    endfunction

    // Memory model: read data only valid in the last cycle of a LATENCY-long strobe
    always @(posedge Clk) begin
        #1;
        run4 = b4.m_readM ? run4 + 1 : 0;
        b4.m_rdata = (b4.m_readM && run4 == 4) ? mem_rd(b4.m_address) : 16'hDEAD;
        if (b4.m_writeM) mem[b4.m_address] = b4.m_wdata;
        run1 = b1.m_readM ? run1 + 1 : 0;
        b1.m_rdata = (b1.m_readM && run1 == 1) ? mem_rd(b1.m_address) : 16'hDEAD;
        if (b1.m_writeM) mem[b1.m_address] = b1.m_wdata;
    end

    // Scoreboard: compare every ready pulse against the oldest expected entry
    always @(negedge Clk) begin
        sb_t e;
        if (b4.i_ready) begin
            if (iq.size() == 0) check_eq("i_unexpected_ready", 1, 0);
            else begin
                e = iq.pop_front();
                check_eq("i_rdata", b4.i_rdata, e.rdata);
            end
        end
        if (b4.d_ready) begin
            if (dq.size() == 0) check_eq("d_unexpected_ready", 1, 0);
            else begin
                e = dq.pop_front();
                if (e.wr) begin
                    check_eq("d_write_mem", mem_rd(e.addr), e.wdata);
                    check_eq("d_rdata_after_write", b4.d_rdata, e.rdata);
                end else begin
                    check_eq("d_rdata", b4.d_rdata, e.rdata);
                end
            end
        end
        if (b1.i_ready) begin
            if (iq1.size() == 0) check_eq("l1_unexpected_ready", 1, 0);
            else begin
                e = iq1.pop_front();
                check_eq("l1_i_rdata", b1.i_rdata, e.rdata);
            end
        end
    end

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic i_fetch4(input logic [W-1:0] a);
        sb_t e;
        int  n;
        e.wr = 1'b0; e.addr = a; e.wdata = '0; e.rdata = mem_rd(a);
        iq.push_back(e);
        b4.i_readM   = 1'b1;
        b4.i_address = a;
        for (n = 1; n <= 20; n++) begin
            @(negedge Clk);
            if (b4.i_ready) break;
        end
        check_eq("i_latency", n, 6);
        b4.i_readM = 1'b0;
    endtask

    task automatic d_access4(input logic wr, input logic [W-1:0] a, input logic [W-1:0] wd);
        sb_t e;
        int  n;
        e.wr = wr; e.addr = a; e.wdata = wd;
        e.rdata = wr ? last_d_rd : mem_rd(a);
        if (!wr) last_d_rd = mem_rd(a);
        dq.push_back(e);
        b4.d_readM   = ~wr;
        b4.d_writeM  = wr;
        b4.d_address = a;
        b4.d_wdata   = wd;
        for (n = 1; n <= 20; n++) begin
            @(negedge Clk);
            if (b4.d_ready) break;
        end
        check_eq("d_latency", n, 6);
        b4.d_readM  = 1'b0;
        b4.d_writeM = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sb_t e;
        mem[16'h0010] = 16'h6A01;
        mem[16'h0040] = 16'h1234;
        mem[16'h0002] = 16'h7002;
        b4.i_readM = 0; b4.i_address = '0; b4.d_readM = 0; b4.d_writeM = 0;
        b4.d_address = '0; b4.d_wdata = '0;
        b1.i_readM = 0; b1.i_address = '0; b1.d_readM = 0; b1.d_writeM = 0;
        b1.d_address = '0; b1.d_wdata = '0;

        Reset_N = 1'b0;
        repeat (3) next_cycle();
        Reset_N = 1'b1;
        @(negedge Clk);
        check_eq("rst_m_readM",   b4.m_readM,   0);
        check_eq("rst_m_writeM",  b4.m_writeM,  0);
        check_eq("rst_i_ready",   b4.i_ready,   0);
        check_eq("rst_d_ready",   b4.d_ready,   0);
        check_eq("rst_i_rdata",   b4.i_rdata,   0);
        check_eq("rst_d_rdata",   b4.d_rdata,   0);
        check_eq("rst_m_address", b4.m_address, 0);
        check_eq("rst_m_wdata",   b4.m_wdata,   0);
        check_eq("rst_l1_m_readM", b1.m_readM,  0);

        // Single fetch with exact cycle timing
        next_cycle();
        e.wr = 0; e.addr = 16'h0010; e.wdata = '0; e.rdata = 16'h6A01;
        iq.push_back(e);
        b4.i_readM = 1'b1; b4.i_address = 16'h0010;
        for (int c = 0; c <= 6; c++) begin
            @(negedge Clk);
            check_eq($sformatf("t1_m_readM_c%0d", c), b4.m_readM, (c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) check_eq("t1_m_address", b4.m_address, 16'h0010);
            check_eq($sformatf("t1_i_ready_c%0d", c), b4.i_ready, (c == 5));
            check_eq($sformatf("t1_i_stall_c%0d", c), b4.i_stall, (c <= 4));
            if (c == 5) b4.i_readM = 1'b0;
            next_cycle();
        end
        check_eq("t1_i_rdata_hold", b4.i_rdata, 16'h6A01);

        // Simultaneous requests: data write first, then the pending fetch
        e.wr = 1; e.addr = 16'h0100; e.wdata = 16'hBEEF; e.rdata = last_d_rd;
        dq.push_back(e);
        e.wr = 0; e.addr = 16'h0002; e.wdata = '0; e.rdata = 16'h7002;
        iq.push_back(e);
        b4.i_readM = 1'b1; b4.i_address = 16'h0002;
        b4.d_writeM = 1'b1; b4.d_address = 16'h0100; b4.d_wdata = 16'hBEEF;
        for (int c = 0; c <= 12; c++) begin
            @(negedge Clk);
            check_eq($sformatf("t2_m_writeM_c%0d", c), b4.m_writeM, (c >= 1 && c <= 4));
            check_eq($sformatf("t2_m_readM_c%0d", c), b4.m_readM, (c >= 7 && c <= 10));
            if (c >= 1 && c <= 4) begin
                check_eq("t2_wr_address", b4.m_address, 16'h0100);
                check_eq("t2_wr_wdata",   b4.m_wdata,   16'hBEEF);
            end
            if (c >= 7 && c <= 10) check_eq("t2_rd_address", b4.m_address, 16'h0002);
            check_eq($sformatf("t2_d_ready_c%0d", c), b4.d_ready, (c == 5));
            check_eq($sformatf("t2_i_ready_c%0d", c), b4.i_ready, (c == 11));
            check_eq($sformatf("t2_d_stall_c%0d", c), b4.d_stall, (c <= 4));
            check_eq($sformatf("t2_i_stall_c%0d", c), b4.i_stall, (c <= 10));
            if (c == 5)  b4.d_writeM = 1'b0;
            if (c == 11) b4.i_readM  = 1'b0;
            next_cycle();
        end

        // Data read then write back-to-back; write must not disturb d_rdata
        d_access4(1'b0, 16'h0040, 16'h0000);
        d_access4(1'b1, 16'h0041, 16'h5555);
        repeat (3) @(negedge Clk);
        check_eq("t3_d_rdata_hold", b4.d_rdata, 16'h1234);

        // Reset in the middle of a fetch aborts it
        next_cycle();
        b4.i_readM = 1'b1; b4.i_address = 16'h0030;
        @(negedge Clk);
        check_eq("t4_i_stall_c0", b4.i_stall, 1);
        next_cycle();
        @(negedge Clk);
        check_eq("t4_m_readM_c1", b4.m_readM, 1);
        next_cycle();
        Reset_N = 1'b0;
        b4.i_readM = 1'b0;
        last_d_rd = '0;
        @(negedge Clk);
        check_eq("t4_m_readM_c2", b4.m_readM, 1);
        next_cycle();
        @(negedge Clk);
        check_eq("t4_m_readM_c3",   b4.m_readM,   0);
        check_eq("t4_m_address_c3", b4.m_address, 0);
        check_eq("t4_i_ready_c3",   b4.i_ready,   0);
        check_eq("t4_state_idle",   dut4.state_q, IDLE);
        Reset_N = 1'b1;
        for (int c = 4; c < 12; c++) begin
            @(negedge Clk);
            check_eq($sformatf("t4_i_ready_c%0d", c), b4.i_ready, 0);
            check_eq($sformatf("t4_m_readM_c%0d", c), b4.m_readM, 0);
        end
        next_cycle();
        i_fetch4(16'h0010);

        // LATENCY=1 instance with a continuously held fetch
        next_cycle();
        e.wr = 0; e.addr = 16'h0010; e.wdata = '0; e.rdata = 16'h6A01;
        repeat (3) iq1.push_back(e);
        b1.i_readM = 1'b1; b1.i_address = 16'h0010;
        for (int c = 0; c <= 9; c++) begin
            @(negedge Clk);
            check_eq($sformatf("t5_m_readM_c%0d", c), b1.m_readM, (c % 3 == 1));
            check_eq($sformatf("t5_i_ready_c%0d", c), b1.i_ready, (c % 3 == 2));
            if (c == 8) b1.i_readM = 1'b0;
            next_cycle();
        end

        // Fetch request pulsed while data side is busy is never served
        next_cycle();
        fork
            d_access4(1'b0, 16'h0040, 16'h0000);
            begin
                next_cycle();
                next_cycle();
                b4.i_readM = 1'b1; b4.i_address = 16'h0077;
                next_cycle();
                b4.i_readM = 1'b0;
            end
        join
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            check_eq($sformatf("t6_m_readM_%0d", c), b4.m_readM, 0);
            check_eq($sformatf("t6_i_ready_%0d", c), b4.i_ready, 0);
        end

        repeat (3) next_cycle();
        check_eq("iq_drained",  iq.size(),  0);
        check_eq("dq_drained",  dq.size(),  0);
        check_eq("iq1_drained", iq1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
